// File: rtl/aes_key_pkg.sv
// ---------------------------------------------------------------------------
// aes_key_pkg
//   Shared definitions for the AES-128 key-schedule sequencer and the key
//   timer side: round count, nominal timer length and the sequencer states.
//   Optional watchdog in the sequencer is enabled by KEY_SCHED_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package aes_key_pkg;

   localparam int AES128_NUM_ROUNDS = 10;
   localparam int KEY_TIMER_CYC     = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WAIT = 3'd1,
      LOAD = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } ks_state_e;

endpackage

// File: rtl/key_sched_watchdog.sv
// ---------------------------------------------------------------------------
// key_sched_watchdog
//   Counts cycles spent waiting on the key timer. Used by key_sched_ctrl only
//   when KEY_SCHED_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the count (entry into the wait phase)
//   enable    : count this cycle (currently waiting)
//   expired   : this enabled cycle is the TIMEOUT_CYC-th one since clear
// ---------------------------------------------------------------------------
module key_sched_watchdog
   import aes_key_pkg::*;
#(
   parameter int TIMEOUT_CYC = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count saturates so it can never wrap back into a non-expired value.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   // cnt_q holds the number of completed wait cycles, so the cycle seeing
   // TIMEOUT_CYC-1 is the one on which the count reaches TIMEOUT_CYC.
   assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// key_sched_ctrl
//   Drives the key-schedule timer: per round, holds key_enable until the timer
//   reports key_done, then strobes round_load so the key datapath latches
//   round key round_idx (1..NUM_ROUNDS). sched_done pulses after the last load.
//   Define KEY_SCHED_TIMEOUT_EN to add a wait watchdog, an ERR state and the
//   timeout_err output.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : request a full schedule (sampled only when idle or in error)
//   key_done    : timer completion (sampled only while waiting)
//   key_enable  : timer count enable
//   round_load  : one-cycle strobe, latch round key round_idx
//   round_idx   : current round number
//   busy        : any state other than IDLE
//   sched_done  : one-cycle pulse after the final round_load
//   timeout_err : watchdog expired (KEY_SCHED_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module key_sched_ctrl
   import aes_key_pkg::*;
#(
   parameter int NUM_ROUNDS  = AES128_NUM_ROUNDS,
   parameter int RIDX_W      = 4,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              key_done,
   output logic              key_enable,
   output logic              round_load,
   output logic [RIDX_W-1:0] round_idx,
   output logic              busy,
   output logic              sched_done
`ifdef KEY_SCHED_TIMEOUT_EN
  ,output logic              timeout_err
`endif
);

   if (2**RIDX_W <= NUM_ROUNDS) begin : g_ridx_chk
      $error("key_sched_ctrl: RIDX_W too narrow for NUM_ROUNDS");
   end

   if (TIMEOUT_CYC < 1) begin : g_to_chk
      $error("key_sched_ctrl: TIMEOUT_CYC must be at least 1");
   end

   ks_state_e         state_q, state_d;
   logic [RIDX_W-1:0] ridx_q, ridx_d;
   logic              key_enable_q, round_load_q, busy_q, sched_done_q;

`ifdef KEY_SCHED_TIMEOUT_EN
   logic wd_expired;
   logic timeout_err_q;

   key_sched_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   ((state_d == WAIT) && (state_q != WAIT)),
      .enable  (state_q == WAIT),
      .expired (wd_expired)
   );
`endif

   always_comb begin
      state_d = state_q;
      ridx_d  = ridx_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WAIT;
               ridx_d  = RIDX_W'(1);
            end
         end
         WAIT: begin
            // key_done has priority over a watchdog expiring the same cycle.
            if (key_done) begin
               state_d = LOAD;
`ifdef KEY_SCHED_TIMEOUT_EN
            end else if (wd_expired) begin
               state_d = ERR;
`endif
            end
         end
         LOAD: begin
            if (ridx_q == RIDX_W'(NUM_ROUNDS)) begin
               state_d = DONE;
            end else begin
               state_d = WAIT;
               ridx_d  = ridx_q + 1'b1;
            end
         end
         DONE: state_d = IDLE;
`ifdef KEY_SCHED_TIMEOUT_EN
         ERR: begin
            if (start) begin
               state_d = WAIT;
               ridx_d  = RIDX_W'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered decodes of the next state, so they line up with
   // state_q on the following cycle and stay glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         ridx_q        <= '0;
         key_enable_q  <= 1'b0;
         round_load_q  <= 1'b0;
         busy_q        <= 1'b0;
         sched_done_q  <= 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
         timeout_err_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         ridx_q        <= ridx_d;
         key_enable_q  <= (state_d == WAIT);
         round_load_q  <= (state_d == LOAD);
         busy_q        <= (state_d != IDLE);
         sched_done_q  <= (state_d == DONE);
`ifdef KEY_SCHED_TIMEOUT_EN
         timeout_err_q <= (state_d == ERR);
`endif
      end
   end

   assign key_enable  = key_enable_q;
   assign round_load  = round_load_q;
   assign round_idx   = ridx_q;
   assign busy        = busy_q;
   assign sched_done  = sched_done_q;
`ifdef KEY_SCHED_TIMEOUT_EN
   assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_sched_ctrl
//   Directed plus randomized bench for key_sched_ctrl. A behavioural model
//   tracks the schedule as flags (running / waiting / loading / done / error)
//   plus a round number and a wait-age counter, and every cycle's outputs are
//   compared against it. Build with KEY_SCHED_TIMEOUT_EN to cover the watchdog.
// ---------------------------------------------------------------------------
module tb_key_sched_ctrl;

   localparam int NR = 10;
   localparam int RW = 4;
   localparam int TO = 32;
`ifdef KEY_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          key_done = 1'b0;
   logic          key_enable, round_load, busy, sched_done;
   logic [RW-1:0] round_idx;
`ifdef KEY_SCHED_TIMEOUT_EN
   logic          timeout_err;
`endif

   always #5 clk = ~clk;

   key_sched_ctrl #(
      .NUM_ROUNDS  (NR),
      .RIDX_W      (RW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .key_done    (key_done),
      .key_enable  (key_enable),
      .round_load  (round_load),
      .round_idx   (round_idx),
      .busy        (busy),
      .sched_done  (sched_done)
`ifdef KEY_SCHED_TIMEOUT_EN
     ,.timeout_err (timeout_err)
`endif
   );

   int errors = 0;
   int checks = 0;
   int loads[$];

   // reference model state
   bit m_run, m_wait, m_load, m_done, m_err;
   int m_rnd, m_wcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge of the schedule rules, inputs as sampled at that edge.
   task automatic model_step(input bit r, input bit s, input bit kd);
      bit was_wait = m_wait, was_load = m_load, was_done = m_done;
      if (r) begin
         {m_run, m_wait, m_load, m_done, m_err} = '0;
         m_rnd = 0; m_wcnt = 0;
         return;
      end
      m_load = 1'b0;
      m_done = 1'b0;
      if (was_wait) begin
         m_wcnt++;
         if (kd) begin
            m_wait = 1'b0; m_load = 1'b1;
         end else if (TO_EN && m_wcnt >= TO) begin
            m_wait = 1'b0; m_err = 1'b1;
         end
      end else if (was_load) begin
         if (m_rnd == NR) m_done = 1'b1;
         else begin m_rnd++; m_wait = 1'b1; m_wcnt = 0; end
      end else if (was_done) begin
         m_run = 1'b0;
      end else if (s) begin
         // idle or error: start begins a fresh schedule
         m_run = 1'b1; m_wait = 1'b1; m_rnd = 1; m_wcnt = 0; m_err = 1'b0;
      end
   endtask

   task automatic tick(input bit r, input bit s, input bit kd);
      rst = r; start = s; key_done = kd;
      @(posedge clk);
      model_step(r, s, kd);
      #1;
      chk("key_enable", key_enable, m_wait);
      chk("round_load", round_load, m_load);
      chk("round_idx",  round_idx,  m_rnd);
      chk("busy",       busy,       m_run);
      chk("sched_done", sched_done, m_done);
`ifdef KEY_SCHED_TIMEOUT_EN
      chk("timeout_err", timeout_err, m_err);
`endif
      if (round_load === 1'b1) loads.push_back(int'(round_idx));
   endtask

   // Timer model: key_done once key_enable has been high for dly cycles.
   function automatic bit tmr(input int dly);
      return m_wait && (m_wcnt >= dly);
   endfunction

   task automatic check_loads(input string tag);
      chk({tag, "_nloads"}, loads.size(), NR);
      for (int k = 0; k < NR; k++)
         chk({tag, "_idx"}, (k < loads.size()) ? loads[k] : -1, k + 1);
   endtask

   initial begin
      int dly;
      bit s, kd;

      // reset
      tick(1, 0, 0);
      tick(1, 0, 0);

      // spurious key_done in idle
      repeat (3) tick(0, 0, 1);

      // nominal run, start re-pulsed during round 3
      loads.delete();
      tick(0, 1, 0);
      for (int i = 0; i < 400 && m_run; i++) begin
         s = m_wait && (m_rnd == 3) && (m_wcnt == 2);
         tick(0, s, tmr(8));
      end
      check_loads("nominal");
      chk("nominal_idle", busy, 1'b0);

      // start and key_done together, then reset mid-operation in round 5
      tick(0, 1, 1);
      chk("st_kd_wait", key_enable, 1'b1);
      chk("st_kd_noload", round_load, 1'b0);
      for (int i = 0; i < 400 && !(m_wait && m_rnd == 5 && m_wcnt == 3); i++)
         tick(0, 0, tmr(4));
      chk("pre_rst_idx", round_idx, 5);
      tick(1, 0, 0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_idx", round_idx, 0);
      loads.delete();
      tick(0, 1, 0);
      chk("restart_idx", round_idx, 1);
      for (int i = 0; i < 400 && m_run; i++) tick(0, 0, tmr(3));
      check_loads("restart");

      // randomized schedules with start / key_done noise
      for (int n = 0; n < 5; n++) begin
         loads.delete();
         tick(0, 1, 0);
         dly = 0;
         for (int i = 0; i < 2000 && m_run; i++) begin
            if (m_wait && m_wcnt == 0)
               dly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                                  : int'($urandom_range(0, 10));
            s  = ($urandom_range(0, 7) == 0);
            kd = m_wait ? tmr(dly) : ($urandom_range(0, 3) == 0);
            tick(0, s, kd);
         end
         chk("rand_idle", busy, 1'b0);
      end

`ifdef KEY_SCHED_TIMEOUT_EN
      // watchdog expiry, then recovery via start
      tick(0, 1, 0);
      repeat (40) tick(0, 0, 0);
      chk("to_err", timeout_err, 1'b1);
      chk("to_en", key_enable, 1'b0);
      chk("to_busy", busy, 1'b1);
      tick(0, 1, 0);
      chk("to_clr", timeout_err, 1'b0);
      chk("to_idx", round_idx, 1);
      // key_done on the 32nd wait cycle wins
      repeat (TO - 1) tick(0, 0, 0);
      tick(0, 0, 1);
      chk("bnd_load", round_load, 1'b1);
      chk("bnd_noerr", timeout_err, 1'b0);
      for (int i = 0; i < 400 && m_run; i++) tick(0, 0, tmr(2));
      chk("bnd_idle", busy, 1'b0);
`else
      // no watchdog: wait persists indefinitely
      tick(0, 1, 0);
      repeat (120) tick(0, 0, 0);
      chk("nowd_en", key_enable, 1'b1);
      chk("nowd_busy", busy, 1'b1);
      chk("nowd_noload", round_load, 1'b0);
      tick(0, 0, 1);
      chk("nowd_load", round_load, 1'b1);
      for (int i = 0; i < 400 && m_run; i++) tick(0, 0, tmr(2));
      chk("nowd_idle", busy, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
